// File: rtl/minv_mdiv_core.sv
// Word-serial modular inverse / modular division core (binary extended GCD).
// Optional RUN-cycle watchdog enabled by defining MINV_MDIV_TIMEOUT_EN.
module minv_mdiv_core #(
   parameter int WIDTH = 256,
   parameter int BUS_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BUS_W-1:0] datain,
   input  logic             loada,
   input  logic             loadb,
   input  logic             loadp,
   input  logic             mode,
   input  logic             start,
   input  logic             outr,
   output logic [BUS_W-1:0] dataout,
   output logic             busy,
   output logic             rdy,
   output logic             err
);

   typedef enum logic [2:0] {IDLE, INIT, RUN, FIN, DONE} state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
   logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             rdy_q, rdy_d, err_q, err_d;

`ifdef MINV_MDIV_TIMEOUT_EN
   localparam int TMAX = 4*WIDTH + 4;
   localparam int TW   = $clog2(TMAX + 1);
   logic [TW-1:0] tmr_q, tmr_d;
`endif

   function automatic logic [WIDTH-1:0] shiftIn(input logic [WIDTH-1:0] r,
                                                input logic [BUS_W-1:0] d);
      logic [WIDTH-1:0] ext;
      ext = '0;
      ext[BUS_W-1:0] = d;
      return (ext << (WIDTH-BUS_W)) | (r >> BUS_W);
   endfunction

   // Odd values get P added first so the halving stays exact modulo P.
   function automatic logic [WIDTH-1:0] halfMod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] p);
      logic [WIDTH:0] sum;
      sum = {1'b0, x} + (x[0] ? {1'b0, p} : {(WIDTH+1){1'b0}});
      return sum[WIDTH:1];
   endfunction

   function automatic logic [WIDTH-1:0] subMod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] p);
      logic [WIDTH:0] diff;
      diff = {1'b0, a} - {1'b0, b};
      if (diff[WIDTH])
         diff = diff + {1'b0, p};
      return diff[WIDTH-1:0];
   endfunction

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      u_d     = u_q;
      v_d     = v_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      res_d   = res_q;
      rdy_d   = rdy_q;
      err_d   = err_q;
`ifdef MINV_MDIV_TIMEOUT_EN
      tmr_d   = tmr_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (loada) a_d = shiftIn(a_q, datain);
            if (loadb) b_d = shiftIn(b_q, datain);
            if (loadp) p_d = shiftIn(p_q, datain);
            if (loada || loadb || loadp) begin
               rdy_d = 1'b0;
               err_d = 1'b0;
            end
            if (outr) res_d = res_q >> BUS_W;
            if (start) begin
               state_d = INIT;
               u_d     = a_q;
               v_d     = p_q;
               x1_d    = mode ? ONE : b_q;
               x2_d    = '0;
               rdy_d   = 1'b0;
               err_d   = 1'b0;
`ifdef MINV_MDIV_TIMEOUT_EN
               tmr_d   = '0;
`endif
            end
         end
         INIT: begin
            if (a_q == '0 || !p_q[0]) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
`ifdef MINV_MDIV_TIMEOUT_EN
            tmr_d = tmr_q + 1'b1;
`endif
            // u hitting zero means u==v earlier, i.e. a common factor with P.
            if (u_q == ONE || v_q == ONE) begin
               state_d = FIN;
            end else if (u_q == '0) begin
               state_d = FIN;
               err_d   = 1'b1;
            end else if (!u_q[0]) begin
               u_d  = u_q >> 1;
               x1_d = halfMod(x1_q, p_q);
            end else if (!v_q[0]) begin
               v_d  = v_q >> 1;
               x2_d = halfMod(x2_q, p_q);
            end else if (u_q >= v_q) begin
               u_d  = u_q - v_q;
               x1_d = subMod(x1_q, x2_q, p_q);
            end else begin
               v_d  = v_q - u_q;
               x2_d = subMod(x2_q, x1_q, p_q);
            end
`ifdef MINV_MDIV_TIMEOUT_EN
            if (tmr_q == TW'(TMAX-1)) begin
               state_d = FIN;
               err_d   = 1'b1;
            end
`endif
         end
         FIN: begin
            res_d   = err_q ? '0 : ((u_q == ONE) ? x1_q : x2_q);
            rdy_d   = 1'b1;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         u_q     <= '0;
         v_q     <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         res_q   <= '0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef MINV_MDIV_TIMEOUT_EN
         tmr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         u_q     <= u_d;
         v_q     <= v_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         res_q   <= res_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
`ifdef MINV_MDIV_TIMEOUT_EN
         tmr_q   <= tmr_d;
`endif
      end
   end

   assign busy    = (state_q == INIT) || (state_q == RUN) || (state_q == FIN);
   assign rdy     = rdy_q;
   assign err     = err_q;
   assign dataout = res_q[BUS_W-1:0];

endmodule

// File: tb/tb_minv_mdiv_core.sv
// Self-checking bench for minv_mdiv_core: a 32-bit and a 64-bit instance,
// directed cases plus random operands checked against an extended-Euclid model.
module tb_minv_mdiv_core;

   logic        clk;
   logic        rst;
   logic [31:0] datain;
   logic        mode;
   logic [1:0]  la, lb, lp, st, ot;
   logic [31:0] dout32, dout64;
   logic [1:0]  busy, rdy, err;

   int nVec;
   int nFail;

   minv_mdiv_core #(.WIDTH(32), .BUS_W(32)) dut32 (
      .clk(clk), .rst(rst), .datain(datain),
      .loada(la[0]), .loadb(lb[0]), .loadp(lp[0]),
      .mode(mode), .start(st[0]), .outr(ot[0]),
      .dataout(dout32), .busy(busy[0]), .rdy(rdy[0]), .err(err[0])
   );

   minv_mdiv_core #(.WIDTH(64), .BUS_W(32)) dut64 (
      .clk(clk), .rst(rst), .datain(datain),
      .loada(la[1]), .loadb(lb[1]), .loadp(lp[1]),
      .mode(mode), .start(st[1]), .outr(ot[1]),
      .dataout(dout64), .busy(busy[1]), .rdy(rdy[1]), .err(err[1])
   );

   // Free-running clock; stimulus and sampling both happen 1ns after posedge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // which: 0 = A, 1 = B, 2 = P
   task automatic applyStimulus(input int sel, input int which,
                                input logic [31:0] w);
      datain = w;
      case (which)
         0:       la[sel] = 1'b1;
         1:       lb[sel] = 1'b1;
         default: lp[sel] = 1'b1;
      endcase
      cyc();
      la = '0;
      lb = '0;
      lp = '0;
   endtask

   task automatic startOp(input int sel, input logic m);
      mode    = m;
      st[sel] = 1'b1;
      cyc();
      st = '0;
   endtask

   task automatic shiftOut(input int sel);
      ot[sel] = 1'b1;
      cyc();
      ot = '0;
   endtask

   task automatic waitDone(input int sel, input int budget);
      int n;
      n = 0;
      while (!rdy[sel] && n < budget) begin
         cyc();
         n++;
      end
      checkOutput("done_in_budget", {63'b0, rdy[sel]}, 64'd1);
   endtask

   task automatic runOp32(input logic [31:0] p, input logic [31:0] a,
                          input logic [31:0] b, input logic m);
      applyStimulus(0, 2, p);
      applyStimulus(0, 0, a);
      applyStimulus(0, 1, b);
      startOp(0, m);
      waitDone(0, 4*32 + 4);
   endtask

   // Reference: B * A^-1 mod P via signed extended Euclid on 64-bit integers.
   function automatic void refModel(input longint p, input longint a,
                                    input longint b, input bit m,
                                    output logic [31:0] r, output bit e);
      longint r0, r1, t0, t1, q, tmp;
      logic [63:0] bu, iu, pu, prod;
      e = 1'b0;
      r = '0;
      if (a == 0 || (p % 2) == 0) begin
         e = 1'b1;
         return;
      end
      r0 = p;  r1 = a;
      t0 = 0;  t1 = 1;
      while (r1 != 0) begin
         q   = r0 / r1;
         tmp = r0 - q*r1;  r0 = r1;  r1 = tmp;
         tmp = t0 - q*t1;  t0 = t1;  t1 = tmp;
      end
      if (r0 != 1) begin
         e = 1'b1;
         return;
      end
      if (t0 < 0) t0 = t0 + p;
      bu   = m ? 64'd1 : b;
      iu   = t0;
      pu   = p;
      prod = (bu * iu) % pu;
      r    = prod[31:0];
   endfunction

   task automatic checkResult32(input string tag, input logic [31:0] p,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic m);
      logic [31:0] expR;
      bit          expE;
      runOp32(p, a, b, m);
      refModel(longint'(p), longint'(a), longint'(b), m, expR, expE);
      checkOutput({tag, "_rdy"},  {63'b0, rdy[0]}, 64'd1);
      checkOutput({tag, "_err"},  {63'b0, err[0]}, {63'b0, expE});
      checkOutput({tag, "_dout"}, {32'b0, dout32}, {32'b0, expR});
   endtask

   initial begin
      logic [31:0] rp, ra, rb;
      logic        rm;
      nVec   = 0;
      nFail  = 0;
      rst    = 1'b0;
      datain = 32'd5;
      mode   = 1'b0;
      lb = '0;  lp = '0;  st = '0;  ot = '0;
      la = 2'b11;
      repeat (3) cyc();
      la = '0;

      checkOutput("rst_busy",  {62'b0, busy}, 64'd0);
      checkOutput("rst_rdy",   {62'b0, rdy},  64'd0);
      checkOutput("rst_err",   {62'b0, err},  64'd0);
      checkOutput("rst_dout",  {dout64, dout32}, 64'd0);

      // Load strobe in the first cycle out of reset; A strobed in reset stays 0.
      rst = 1'b1;
      applyStimulus(0, 2, 32'd23);
      startOp(0, 1'b1);
      waitDone(0, 132);
      checkOutput("rst_strobe_ignored_err", {63'b0, err[0]}, 64'd1);
      checkOutput("rst_strobe_ignored_dout", {32'b0, dout32}, 64'd0);

      checkResult32("inv_5_23", 32'd23, 32'd5, 32'd0, 1'b1);
      checkOutput("inv_5_23_val", {32'b0, dout32}, 64'd14);
      checkResult32("div_7_5_23", 32'd23, 32'd5, 32'd7, 1'b0);
      checkOutput("div_7_5_23_val", {32'b0, dout32}, 64'd6);
      checkResult32("div_9_1_23", 32'd23, 32'd1, 32'd9, 1'b0);
      checkOutput("div_9_1_23_val", {32'b0, dout32}, 64'd9);

      applyStimulus(0, 1, 32'd4);
      checkOutput("load_clears_rdy", {63'b0, rdy[0]}, 64'd0);

      checkResult32("a_zero", 32'd23, 32'd0, 32'd3, 1'b0);
      checkOutput("a_zero_err", {63'b0, err[0]}, 64'd1);
      checkResult32("p_even", 32'd22, 32'd5, 32'd0, 1'b1);
      checkOutput("p_even_err", {63'b0, err[0]}, 64'd1);
      checkResult32("gcd3", 32'd9, 32'd6, 32'd0, 1'b1);
      checkOutput("gcd3_err", {63'b0, err[0]}, 64'd1);

      // 64-bit instance: two-word operands, R = (P+1)/2 for A = 2.
      applyStimulus(1, 2, 32'h0000_0007);
      applyStimulus(1, 2, 32'h0000_0001);
      applyStimulus(1, 0, 32'h0000_0002);
      applyStimulus(1, 0, 32'h0000_0000);
      startOp(1, 1'b1);
      waitDone(1, 4*64 + 4);
      checkOutput("w64_err",  {63'b0, err[1]}, 64'd0);
      checkOutput("w64_lo",   {32'b0, dout64}, 64'h8000_0004);
      shiftOut(1);
      checkOutput("w64_hi",   {32'b0, dout64}, 64'h0);
      checkOutput("w64_busy", {63'b0, busy[1]}, 64'd0);

      // Start and load while busy are ignored.
      runOp32(32'd23, 32'd5, 32'd0, 1'b1);
      startOp(0, 1'b1);
      cyc();
      checkOutput("busy_high", {63'b0, busy[0]}, 64'd1);
      datain = 32'd3;
      la[0]  = 1'b1;
      st[0]  = 1'b1;
      mode   = 1'b0;
      cyc();
      la = '0;
      st = '0;
      waitDone(0, 132);
      checkOutput("busy_start_ignored", {32'b0, dout32}, 64'd14);
      startOp(0, 1'b1);
      waitDone(0, 132);
      checkOutput("busy_load_ignored", {32'b0, dout32}, 64'd14);

      // Reset two cycles after start aborts and clears the held result.
      startOp(0, 1'b1);
      cyc();
      rst = 1'b0;
      cyc();
      checkOutput("abort_busy", {63'b0, busy[0]}, 64'd0);
      checkOutput("abort_rdy",  {63'b0, rdy[0]},  64'd0);
      checkOutput("abort_dout", {32'b0, dout32},  64'd0);
      rst = 1'b1;

      for (int i = 0; i < 24; i++) begin
         if (i % 3 == 0) rp = 32'($urandom_range(3, 200)) | 32'd1;
         else            rp = $urandom | 32'd1;
         if (rp == 32'd1) rp = 32'd3;
         ra = 32'd1 + ($urandom % (rp - 32'd1));
         rb = $urandom % rp;
         rm = 1'($urandom_range(0, 1));
         checkResult32($sformatf("rnd%0d", i), rp, ra, rb, rm);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
